// File: rtl/rll_2_7_pkg.sv
// Shared constants for the RLL(2,7) receive path: codewords, their lengths,
// left-aligned data words and the encoding used for data-word lengths.
package rll_2_7_pkg;

  localparam int D_MIN_DEF = 2;
  localparam int K_MAX_DEF = 7;

  // Codewords, first received bit is the MSB
  localparam logic [3:0] CW_10   = 4'b0100;
  localparam logic [3:0] CW_11   = 4'b1000;
  localparam logic [5:0] CW_000  = 6'b000100;
  localparam logic [5:0] CW_010  = 6'b100100;
  localparam logic [5:0] CW_011  = 6'b001000;
  localparam logic [7:0] CW_0010 = 8'b00100100;
  localparam logic [7:0] CW_0011 = 8'b00001000;

  // Accumulator lengths at which a match is attempted
  localparam logic [3:0] CW_LEN_SHORT = 4'd4;
  localparam logic [3:0] CW_LEN_MID   = 4'd6;
  localparam logic [3:0] CW_LEN_LONG  = 4'd8;

  // Data words, left-aligned in a 4-bit field
  localparam logic [3:0] DW_10   = 4'b1000;
  localparam logic [3:0] DW_11   = 4'b1100;
  localparam logic [3:0] DW_000  = 4'b0000;
  localparam logic [3:0] DW_010  = 4'b0100;
  localparam logic [3:0] DW_011  = 4'b0110;
  localparam logic [3:0] DW_0010 = 4'b0010;
  localparam logic [3:0] DW_0011 = 4'b0011;

  // Data-word length encoding (number of data bits)
  localparam logic [2:0] DLEN_NONE = 3'd0;
  localparam logic [2:0] DLEN_2    = 3'd2;
  localparam logic [2:0] DLEN_3    = 3'd3;
  localparam logic [2:0] DLEN_4    = 3'd4;

endpackage

// File: rtl/rll_2_7_decode_lut.sv
// Combinational codeword lookup. Because the code set is prefix-free, a match
// is only attempted at lengths 4, 6 and 8; an unmatched 8-bit accumulator is
// an invalid codeword.
module rll_2_7_decode_lut
  import rll_2_7_pkg::*;
(
  input  logic [7:0] acc,
  input  logic [3:0] acc_len,
  output logic       match,
  output logic       invalid,
  output logic [3:0] data_word,
  output logic [2:0] data_len
);

  // Match the low acc_len bits of the accumulator against the code table
  always_comb begin
    match     = 1'b0;
    invalid   = 1'b0;
    data_word = 4'b0000;
    data_len  = DLEN_NONE;
    case (acc_len)
      CW_LEN_SHORT: begin
        if (acc[3:0] == CW_10) begin
          match = 1'b1; data_word = DW_10; data_len = DLEN_2;
        end else if (acc[3:0] == CW_11) begin
          match = 1'b1; data_word = DW_11; data_len = DLEN_2;
        end
      end
      CW_LEN_MID: begin
        if (acc[5:0] == CW_000) begin
          match = 1'b1; data_word = DW_000; data_len = DLEN_3;
        end else if (acc[5:0] == CW_010) begin
          match = 1'b1; data_word = DW_010; data_len = DLEN_3;
        end else if (acc[5:0] == CW_011) begin
          match = 1'b1; data_word = DW_011; data_len = DLEN_3;
        end
      end
      CW_LEN_LONG: begin
        if (acc == CW_0010) begin
          match = 1'b1; data_word = DW_0010; data_len = DLEN_4;
        end else if (acc == CW_0011) begin
          match = 1'b1; data_word = DW_0011; data_len = DLEN_4;
        end else begin
          invalid = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rll_2_7_decoder.sv
// RLL(2,7) decoder: parses the recovered code-bit stream into data bits,
// packs them MSB-first into bytes on a valid/ready interface, and flags
// invalid codewords, run-length violations and overruns.
module rll_2_7_decoder
  import rll_2_7_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter int K_MAX     = K_MAX_DEF,
  parameter int D_MIN     = D_MIN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 code_bit,
  input  logic                 code_bit_valid,
  input  logic                 align,
  output logic [7:0]           data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 code_error,
  output logic                 rll_violation,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [3:0] RUN_LIMIT = 4'(K_MAX + 1);
  localparam logic [3:0] D_LIMIT   = 4'(D_MIN);

  logic [7:0]  acc;
  logic [3:0]  acc_len;
  logic [11:0] pk;
  logic [3:0]  pk_cnt;
  logic [3:0]  run_cnt;
  logic        armed;

  logic        bit_take;
  logic [7:0]  acc_sh;
  logic [3:0]  len_sh;
  logic        lut_match;
  logic        lut_invalid;
  logic [3:0]  lut_word;
  logic [2:0]  lut_len;
  logic [11:0] merged;
  logic [3:0]  cnt_m;
  logic        byte_done;
  logic [3:0]  run_inc;

  // align wins over a code bit arriving in the same cycle
  assign bit_take = enable && code_bit_valid && !align;
  assign acc_sh   = {acc[6:0], code_bit};
  assign len_sh   = acc_len + 4'd1;
  assign run_inc  = (run_cnt == 4'hF) ? run_cnt : run_cnt + 4'd1;

  rll_2_7_decode_lut u_lut (
    .acc       (acc_sh),
    .acc_len   (len_sh),
    .match     (lut_match),
    .invalid   (lut_invalid),
    .data_word (lut_word),
    .data_len  (lut_len)
  );

  // Merge a matched data word into the packer and detect a completed byte
  always_comb begin
    merged = pk;
    cnt_m  = pk_cnt;
    if (bit_take && lut_match) begin
      merged = pk | ({lut_word, 8'h00} >> pk_cnt);
      cnt_m  = pk_cnt + {1'b0, lut_len};
    end
    byte_done = (cnt_m >= 4'd8);
  end

  // Accumulator, packer, run tracking, error counting and output handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      acc           <= '0;
      acc_len       <= '0;
      pk            <= '0;
      pk_cnt        <= '0;
      run_cnt       <= '0;
      armed         <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      code_error    <= 1'b0;
      rll_violation <= 1'b0;
      overrun       <= 1'b0;
      err_count     <= '0;
    end else begin
      code_error    <= 1'b0;
      rll_violation <= 1'b0;
      if (enable) begin
        if (align) begin
          acc     <= '0;
          acc_len <= '0;
          pk      <= '0;
          pk_cnt  <= '0;
          run_cnt <= '0;
          armed   <= 1'b0;
          overrun <= 1'b0;
        end else if (code_bit_valid) begin
          if (lut_match || lut_invalid) begin
            acc     <= '0;
            acc_len <= '0;
          end else begin
            acc     <= acc_sh;
            acc_len <= len_sh;
          end
          if (byte_done) begin
            pk     <= merged << 8;
            pk_cnt <= cnt_m - 4'd8;
          end else begin
            pk     <= merged;
            pk_cnt <= cnt_m;
          end
          if (lut_invalid) begin
            code_error <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
          end
          if (code_bit) begin
            if (armed && (run_cnt < D_LIMIT)) rll_violation <= 1'b1;
            run_cnt <= '0;
            armed   <= 1'b1;
          end else begin
            run_cnt <= run_inc;
            // run_inc differs from run_cnt only while counting, so one pulse per run
            if (armed && (run_inc == RUN_LIMIT) && (run_inc != run_cnt))
              rll_violation <= 1'b1;
          end
        end
        if (byte_done) begin
          data_out   <= merged[11:4];
          data_valid <= 1'b1;
          if (data_valid && !data_ready) overrun <= 1'b1;
        end else if (data_valid && data_ready) begin
          data_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rll_2_7_decoder.sv
// Directed bench for the RLL(2,7) decoder: a table of single-byte code
// streams plus hand sequences for latency, errors, overrun, align and reset.
module tb_rll_2_7_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       code_bit;
  logic       code_bit_valid;
  logic       align;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       code_error;
  logic       rll_violation;
  logic       overrun;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int n_err_pulse = 0;
  int n_viol_pulse = 0;
  logic [7:0] got[$];

  typedef struct {
    logic [15:0] bits;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  rll_2_7_decoder dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .code_bit       (code_bit),
    .code_bit_valid (code_bit_valid),
    .align          (align),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .code_error     (code_error),
    .rll_violation  (rll_violation),
    .overrun        (overrun),
    .err_count      (err_count)
  );

  // Collect accepted bytes and count pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (data_valid === 1'b1 && data_ready === 1'b1) got.push_back(data_out);
    if (code_error === 1'b1) n_err_pulse++;
    if (rll_violation === 1'b1) n_viol_pulse++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    code_bit = b;
    code_bit_valid = 1'b1;
    @(posedge clk);
    #1;
    code_bit_valid = 1'b0;
    code_bit = 1'b0;
  endtask

  task automatic send_code(input logic [15:0] cw, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit(cw[i]);
  endtask

  task automatic do_align();
    align = 1'b1;
    @(posedge clk);
    #1;
    align = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int e0;
    int v0;
    vecs[0] = '{16'b1000_0100_1000_0100, 8'hEE};
    vecs[1] = '{16'b0100_0100_0100_0100, 8'hAA};
    vecs[2] = '{16'b0100_1000_0100_1000, 8'hBB};
    vecs[3] = '{16'b00100100_00001000,   8'h23};
    vecs[4] = '{16'b100100_001000_0100,  8'h4E};
    vecs[5] = '{16'b000100_100100_0100,  8'h0A};

    reset = 1'b1;
    enable = 1'b1;
    code_bit = 1'b0;
    code_bit_valid = 1'b0;
    align = 1'b0;
    data_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    check("rst_code_error", 32'(code_error), 32'h0);
    check("rst_rll_violation", 32'(rll_violation), 32'h0);

    // Latency of the first byte: valid exactly one clock after bit 16
    do_align();
    got.delete();
    send_code(16'b1000_0100_1000_0100 >> 1, 15);
    check("lat_pre_valid", 32'(data_valid), 32'h0);
    send_bit(1'b0);
    check("lat_valid", 32'(data_valid), 32'h1);
    check("lat_byte", 32'(data_out), 32'hEE);
    idle(2);
    check("lat_consumed", 32'(data_valid), 32'h0);

    // Table-driven single-byte streams
    for (int k = 0; k < 6; k++) begin
      got.delete();
      e0 = n_err_pulse;
      v0 = n_viol_pulse;
      do_align();
      send_code(vecs[k].bits, 16);
      idle(2);
      check($sformatf("vec%0d_count", k), 32'(got.size()), 32'd1);
      check($sformatf("vec%0d_byte", k), (got.size() > 0) ? 32'(got[0]) : 32'hxxxxxxxx, 32'(vecs[k].exp));
      check($sformatf("vec%0d_pulses", k), 32'((n_err_pulse - e0) + (n_viol_pulse - v0)), 32'd0);
    end

    // Eight 000100 codewords: byte boundaries fall inside codewords
    got.delete();
    v0 = n_viol_pulse;
    do_align();
    for (int k = 0; k < 8; k++) begin
      send_code(16'b000100, 6);
      check($sformatf("zeros_valid%0d", k), 32'(data_valid), (k == 2 || k == 5 || k == 7) ? 32'h1 : 32'h0);
    end
    idle(2);
    check("zeros_count", 32'(got.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("zeros_byte%0d", k), (got.size() > k) ? 32'(got[k]) : 32'hxxxxxxxx, 32'h00);
    check("zeros_viol", 32'(n_viol_pulse - v0), 32'd0);

    // Invalid codeword 11001100, then recovery
    got.delete();
    do_align();
    send_bit(1'b1);
    send_bit(1'b1);
    check("bad_viol_bit2", 32'(rll_violation), 32'h1);
    send_code(16'b001100, 6);
    check("bad_code_error", 32'(code_error), 32'h1);
    check("bad_err_count", 32'(err_count), 32'd1);
    check("bad_no_byte", 32'(data_valid), 32'h0);
    send_code(16'b0100_0100_0100_0100, 16);
    idle(2);
    check("bad_recover", (got.size() > 0) ? 32'(got[0]) : 32'hxxxxxxxx, 32'hAA);

    // Overrun with a stalled consumer, cleared by align, then accept
    data_ready = 1'b0;
    got.delete();
    do_align();
    send_code(16'b1000_0100_1000_0100, 16);
    check("ovr_first", 32'(data_out), 32'hEE);
    check("ovr_not_yet", 32'(overrun), 32'h0);
    send_code(16'b0100_0100_0100_0100, 16);
    check("ovr_second", 32'(data_out), 32'hAA);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_valid", 32'(data_valid), 32'h1);
    do_align();
    check("ovr_align_clr", 32'(overrun), 32'h0);
    check("ovr_align_hold_valid", 32'(data_valid), 32'h1);
    check("ovr_align_hold_data", 32'(data_out), 32'hAA);
    data_ready = 1'b1;
    idle(1);
    check("ovr_accept", 32'(data_valid), 32'h0);

    // Partial codeword and partial byte discarded by align; same-cycle bit ignored
    do_align();
    send_code(16'b0100, 4);
    send_code(16'b0010, 4);
    align = 1'b1;
    code_bit = 1'b1;
    code_bit_valid = 1'b1;
    @(posedge clk);
    #1;
    align = 1'b0;
    code_bit_valid = 1'b0;
    code_bit = 1'b0;
    got.delete();
    send_code(16'b0100_1000_0100_1000, 16);
    idle(2);
    check("align_count", 32'(got.size()), 32'd1);
    check("align_byte", (got.size() > 0) ? 32'(got[0]) : 32'hxxxxxxxx, 32'hBB);

    // enable low: bits ignored, no pulses, decoding resumes unaffected
    got.delete();
    v0 = n_viol_pulse;
    do_align();
    send_code(16'b01001000, 8);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_bit(1'b1);
      check($sformatf("en_low_viol%0d", k), 32'(rll_violation), 32'h0);
    end
    enable = 1'b1;
    send_code(16'b01001000, 8);
    idle(2);
    check("en_byte", (got.size() > 0) ? 32'(got[0]) : 32'hxxxxxxxx, 32'hBB);
    check("en_viol", 32'(n_viol_pulse - v0), 32'd0);

    // Reset with 5 data bits packed
    do_align();
    send_code(16'b0100, 4);
    send_code(16'b000100, 6);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_data_out", 32'(data_out), 32'h00);
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    check("mid_rst_err_count", 32'(err_count), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    got.delete();
    send_code(16'b0100_0100_0100_0100, 16);
    idle(2);
    check("mid_rst_count", 32'(got.size()), 32'd1);
    check("mid_rst_byte", (got.size() > 0) ? 32'(got[0]) : 32'hxxxxxxxx, 32'hAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
